// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and width-independent constants for alu_mc.
package alu_mc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_SLTU  = 4'd2;
  localparam logic [OPC_W-1:0] OP_SLT   = 4'd3;
  localparam logic [OPC_W-1:0] OP_SLL   = 4'd4;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd5;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd6;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_SRL   = 4'd8;
  localparam logic [OPC_W-1:0] OP_SRA   = 4'd9;
  localparam logic [OPC_W-1:0] OP_NOR   = 4'd10;
  localparam logic [OPC_W-1:0] OP_MULTU = 4'd12;
  localparam logic [OPC_W-1:0] OP_DIVU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between the datapath control and alu_mc.
interface alu_mc_if #(parameter int WIDTH = 32);
  import alu_mc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] opcode;
  logic [WIDTH-1:0] rega;
  logic [WIDTH-1:0] regb;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             div0;
  logic             illegal;
  logic             done;

  modport master (
    output in_valid, opcode, rega, regb,
    input  in_ready, result_lo, result_hi, zero, ovf, div0, illegal, done
  );

  modport slave (
    input  in_valid, opcode, rega, regb,
    output in_ready, result_lo, result_hi, zero, ovf, div0, illegal, done
  );

endinterface

// File: rtl/alu_mc_muldiv.sv
// Iterative engine: WIDTH shift-add multiply steps or restoring divide steps.
// Divider datapath present only when ALU_MC_DIV_EN is defined.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_sh_nxt;

`ifdef ALU_MC_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_rem_sub;
`else
  logic             w_unused_div;
  assign w_unused_div = i_div;
`endif

  // One step: acc:sh holds the running product (hi:lo) or remainder:quotient
  always_comb begin
    w_mul_sum = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});
`ifdef ALU_MC_DIV_EN
    w_rem_sh  = {r_acc, r_sh[WIDTH-1]};
    w_rem_sub = {1'b0, w_rem_sh} - {2'b00, r_op};
    if (r_div) begin
      if (w_rem_sub[WIDTH+1]) begin
        w_acc_nxt = w_rem_sh[WIDTH-1:0];
        w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
      end else begin
        w_acc_nxt = w_rem_sub[WIDTH-1:0];
        w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_acc_nxt = w_mul_sum[WIDTH:1];
      w_sh_nxt  = {w_mul_sum[0], r_sh[WIDTH-1:1]};
    end
`else
    w_acc_nxt = w_mul_sum[WIDTH:1];
    w_sh_nxt  = {w_mul_sum[0], r_sh[WIDTH-1:1]};
`endif
  end

  // Operand load on start, then one step per cycle while the counter is nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_acc <= {WIDTH{1'b0}};
      r_sh  <= {WIDTH{1'b0}};
      r_op  <= {WIDTH{1'b0}};
`ifdef ALU_MC_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_cnt <= CW'(WIDTH);
      r_acc <= {WIDTH{1'b0}};
`ifdef ALU_MC_DIV_EN
      r_div <= i_div;
      r_sh  <= i_div ? i_a : i_b;
      r_op  <= i_div ? i_b : i_a;
`else
      r_sh  <= i_b;
      r_op  <= i_a;
`endif
    end else if (r_cnt != {CW{1'b0}}) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= w_acc_nxt;
      r_sh  <= w_sh_nxt;
    end
  end

  assign o_last   = (r_cnt == CW'(1));
  assign o_lo_nxt = w_sh_nxt;
  assign o_hi_nxt = w_acc_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU with HI/LO.
// Define ALU_MC_DIV_EN to implement DIVU; otherwise opcode 13 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_div0;
  logic             r_illegal;

  logic             w_accept;
  logic             w_start;
  logic             w_load;
  logic             w_finish;
  logic             w_iter_op;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_ovf;
  logic             w_div0;
  logic             w_illegal;
  logic             w_eng_last;
  logic [WIDTH-1:0] w_eng_lo;
  logic [WIDTH-1:0] w_eng_hi;

  assign w_accept = bus.in_valid && r_ready;
  assign w_shamt  = bus.rega[SH_W-1:0];
  assign w_sum    = bus.rega + bus.regb;
  assign w_diff   = bus.rega - bus.regb;

  // Ops that go through the iterative engine
  always_comb begin
    w_iter_op = 1'b0;
    if (bus.opcode == OP_MULTU) begin
      w_iter_op = 1'b1;
`ifdef ALU_MC_DIV_EN
    end else if ((bus.opcode == OP_DIVU) && (bus.regb != {WIDTH{1'b0}})) begin
      w_iter_op = 1'b1;
`endif
    end else begin
      w_iter_op = 1'b0;
    end
  end

  // Single-cycle result and flag computation
  always_comb begin
    w_res_lo  = {WIDTH{1'b0}};
    w_res_hi  = {WIDTH{1'b0}};
    w_ovf     = 1'b0;
    w_div0    = 1'b0;
    w_illegal = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        w_res_lo = w_sum;
        w_ovf    = (bus.rega[WIDTH-1] == bus.regb[WIDTH-1]) && (w_sum[WIDTH-1] != bus.rega[WIDTH-1]);
      end
      OP_SUB: begin
        w_res_lo = w_diff;
        w_ovf    = (bus.rega[WIDTH-1] != bus.regb[WIDTH-1]) && (w_diff[WIDTH-1] != bus.rega[WIDTH-1]);
      end
      OP_SLTU:  w_res_lo = {{(WIDTH-1){1'b0}}, (bus.rega < bus.regb)};
      OP_SLT:   w_res_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.rega) < $signed(bus.regb))};
      OP_SLL:   w_res_lo = bus.regb << w_shamt;
      OP_OR:    w_res_lo = bus.rega | bus.regb;
      OP_AND:   w_res_lo = bus.rega & bus.regb;
      OP_XOR:   w_res_lo = bus.rega ^ bus.regb;
      OP_SRL:   w_res_lo = bus.regb >> w_shamt;
      OP_SRA:   w_res_lo = $unsigned($signed(bus.regb) >>> w_shamt);
      OP_NOR:   w_res_lo = ~(bus.rega | bus.regb);
      OP_MULTU: w_res_lo = {WIDTH{1'b0}};
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        if (bus.regb == {WIDTH{1'b0}}) begin
          w_res_lo = {WIDTH{1'b1}};
          w_res_hi = bus.rega;
          w_div0   = 1'b1;
        end else begin
          w_div0   = 1'b0;
        end
      end
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

  // Next-state logic and datapath load strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_iter_op) begin
          w_state_nxt = ST_ITER;
          w_start     = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (w_eng_last) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = ST_ITER;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_div    (bus.opcode == OP_DIVU),
    .i_a      (bus.rega),
    .i_b      (bus.regb),
    .o_last   (w_eng_last),
    .o_lo_nxt (w_eng_lo),
    .o_hi_nxt (w_eng_hi)
  );

  // State, handshake and result registers; results change only on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_lo      <= {WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_div0    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_lo      <= w_res_lo;
        r_hi      <= w_res_hi;
        r_zero    <= !w_illegal && (w_res_lo == {WIDTH{1'b0}});
        r_ovf     <= w_ovf;
        r_div0    <= w_div0;
        r_illegal <= w_illegal;
      end else if (w_finish) begin
        r_lo      <= w_eng_lo;
        r_hi      <= w_eng_hi;
        r_zero    <= (w_eng_lo == {WIDTH{1'b0}});
        r_ovf     <= 1'b0;
        r_div0    <= 1'b0;
        r_illegal <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.done      = r_done;
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.div0      = r_div0;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=16.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   lat;
  bit   rdy_seen;
  int   done_cnt;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus32 ();
  alu_mc_if #(.WIDTH(16)) bus16 ();

  alu_mc #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  alu_mc #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w16, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      bus16.in_valid = v;
      bus16.opcode   = op;
      bus16.rega     = a[15:0];
      bus16.regb     = b[15:0];
    end else begin
      bus32.in_valid = v;
      bus32.opcode   = op;
      bus32.rega     = a;
      bus32.regb     = b;
    end
  endtask

  // Issue one op (waiting for in_ready), optionally keep in_valid high with junk
  // while busy, and return the done latency in cycles after the accept edge.
  task automatic run_op(input bit w16, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise,
                        output int latency, output bit rdy_busy);
    int g;
    int k;
    g = 0;
    latency = -1;
    rdy_busy = 1'b0;
    while (!(w16 ? bus16.in_ready : bus32.in_ready) && g < 100) begin
      @(negedge clk);
      g++;
    end
    drive(w16, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(w16, noise, noise ? 4'd0 : op, 32'h0000_0001, 32'h0000_0001);
    k = 0;
    while (latency < 0 && k < 100) begin
      @(negedge clk);
      k++;
      if (w16 ? bus16.in_ready : bus32.in_ready) rdy_busy = 1'b1;
      if (w16 ? bus16.done : bus32.done) latency = k;
    end
    drive(w16, 1'b0, 4'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [3:0] flags32();
    return {bus32.zero, bus32.ovf, bus32.div0, bus32.illegal};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",  bus32.in_ready, 1'b0);
    check("rst_done",   bus32.done, 1'b0);
    check("rst_lo",     bus32.result_lo, 32'h0);
    check("rst_hi",     bus32.result_hi, 32'h0);
    check("rst_flags",  flags32(), 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready",  bus32.in_ready, 1'b1);

    // Reset asserted in the middle of a MULTU
    drive(1'b0, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    check("iter_ready", bus32.in_ready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", bus32.in_ready, 1'b0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done) done_cnt++;
    end
    check("abort_done",  done_cnt, 0);
    check("abort_ready", bus32.in_ready, 1'b1);
    check("abort_lo",    bus32.result_lo, 32'h0);
    check("abort_hi",    bus32.result_hi, 32'h0);

    // Signed overflow on ADD
    run_op(1'b0, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, rdy_seen);
    check("add_lo",    bus32.result_lo, 32'h8000_0000);
    check("add_hi",    bus32.result_hi, 32'h0);
    check("add_flags", flags32(), 4'b0100);
    check("add_lat",   lat, 1);
    check("add_rdy",   rdy_seen, 1'b0);

    run_op(1'b0, 4'd1, 32'd5, 32'd5, 1'b0, lat, rdy_seen);
    check("sub_lo",    bus32.result_lo, 32'h0);
    check("sub_flags", flags32(), 4'b1000);

    run_op(1'b0, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, rdy_seen);
    check("slt_lo",    bus32.result_lo, 32'h1);
    check("slt_flags", flags32(), 4'b0000);

    run_op(1'b0, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, rdy_seen);
    check("sltu_lo",    bus32.result_lo, 32'h0);
    check("sltu_flags", flags32(), 4'b1000);

    run_op(1'b0, 4'd9, 32'd36, 32'h8000_0000, 1'b0, lat, rdy_seen);
    check("sra_lo", bus32.result_lo, 32'hF800_0000);

    run_op(1'b0, 4'd8, 32'd4, 32'h8000_0000, 1'b0, lat, rdy_seen);
    check("srl_lo", bus32.result_lo, 32'h0800_0000);

    run_op(1'b0, 4'd4, 32'd33, 32'h0000_0001, 1'b0, lat, rdy_seen);
    check("sll_lo", bus32.result_lo, 32'h0000_0002);

    run_op(1'b0, 4'd10, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, lat, rdy_seen);
    check("nor_lo", bus32.result_lo, 32'hF0F0_FF0F);

    run_op(1'b0, 4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, lat, rdy_seen);
    check("xor_lo", bus32.result_lo, 32'hF0F0_F0F0);

    // MULTU with in_valid held high during ITER
    run_op(1'b0, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, rdy_seen);
    check("mul_hi",    bus32.result_hi, 32'hFFFF_FFFE);
    check("mul_lo",    bus32.result_lo, 32'h0000_0001);
    check("mul_flags", flags32(), 4'b0000);
    check("mul_lat",   lat, 33);
    check("mul_rdy",   rdy_seen, 1'b0);

    run_op(1'b0, 4'd12, 32'd1234, 32'd5678, 1'b0, lat, rdy_seen);
    check("mul2_lo", bus32.result_lo, 32'd7006652);
    check("mul2_hi", bus32.result_hi, 32'h0);

    run_op(1'b0, 4'd13, 32'd100, 32'd7, 1'b0, lat, rdy_seen);
`ifdef ALU_MC_DIV_EN
    check("div_lo",    bus32.result_lo, 32'd14);
    check("div_hi",    bus32.result_hi, 32'd2);
    check("div_flags", flags32(), 4'b0000);
    check("div_lat",   lat, 33);
`else
    check("div_lo",    bus32.result_lo, 32'h0);
    check("div_hi",    bus32.result_hi, 32'h0);
    check("div_flags", flags32(), 4'b0001);
    check("div_lat",   lat, 1);
`endif

    run_op(1'b0, 4'd13, 32'd9, 32'd0, 1'b0, lat, rdy_seen);
`ifdef ALU_MC_DIV_EN
    check("div0_lo",    bus32.result_lo, 32'hFFFF_FFFF);
    check("div0_hi",    bus32.result_hi, 32'd9);
    check("div0_flags", flags32(), 4'b0010);
`else
    check("div0_lo",    bus32.result_lo, 32'h0);
    check("div0_hi",    bus32.result_hi, 32'h0);
    check("div0_flags", flags32(), 4'b0001);
`endif
    check("div0_lat", lat, 1);

    run_op(1'b0, 4'd15, 32'd3, 32'd4, 1'b0, lat, rdy_seen);
    check("ill_lo",    bus32.result_lo, 32'h0);
    check("ill_hi",    bus32.result_hi, 32'h0);
    check("ill_flags", flags32(), 4'b0001);
    check("ill_lat",   lat, 1);

    run_op(1'b0, 4'd11, 32'd3, 32'd4, 1'b0, lat, rdy_seen);
    check("ill11_flags", flags32(), 4'b0001);

    // Results hold through IDLE
    repeat (3) @(negedge clk);
    check("hold_flags", flags32(), 4'b0001);
    check("hold_done",  bus32.done, 1'b0);

    // WIDTH = 16 instance
    run_op(1'b1, 4'd12, 32'h0000_FFFF, 32'h0000_0002, 1'b0, lat, rdy_seen);
    check("m16_hi",  bus16.result_hi, 16'h0001);
    check("m16_lo",  bus16.result_lo, 16'hFFFE);
    check("m16_lat", lat, 17);

    run_op(1'b1, 4'd0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, lat, rdy_seen);
    check("a16_lo",  bus16.result_lo, 16'h8000);
    check("a16_ovf", bus16.ovf, 1'b1);
    check("a16_lat", lat, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the multi-cycle MIPS datapath: a generalised successor to the 32-bit combinational ALU, adding variable width, right shifts/NOR, an iterative unsigned multiplier and divider producing HI/LO, registered flags, and a valid/ready/done handshake. It sits between the register-file operand latches and the ALUOut/HI/LO registers, and the control FSM waits on `done` for long operations.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 8, power of two.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE; request accepted when `in_valid && in_ready`.
- `opcode`  in  4  operation select, sampled at accept.
- `rega`  in  WIDTH  operand A; shift amount for shifts; multiplicand/dividend.
- `regb`  in  WIDTH  operand B; value shifted; multiplier/divisor.
- `result_lo`  out  WIDTH  result; product low half; quotient.
- `result_hi`  out  WIDTH  product high half; remainder; 0 for other ops.
- `zero`  out  1  `result_lo == 0`.
- `ovf`  out  1  signed overflow, ADD/SUB only.
- `div0`  out  1  DIVU with `regb == 0`.
- `illegal`  out  1  unassigned opcode.
- `done`  out  1  one-cycle pulse; results/flags valid from this cycle until next accept.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SLTU, 3 SLT (two's-complement signed), 4 SLL `regb << rega[$clog2(WIDTH)-1:0]`, 5 OR, 6 AND, 7 XOR, 8 SRL, 9 SRA (same shift-amount rule), 10 NOR, 12 MULTU, 13 DIVU; 11, 14, 15 illegal.
- SLT/SLTU write 1 or 0 into `result_lo` bit 0, upper bits zero.
- ADD/SUB wrap modulo 2^WIDTH; `ovf` set when operand signs make the signed result unrepresentable.
- FSM states: IDLE, ITER, DONE.
  - IDLE → DONE on accept of single-cycle op, illegal op, or DIVU with zero divisor.
  - IDLE → ITER on accept of MULTU, or DIVU with nonzero divisor; iteration counter loaded with WIDTH.
  - ITER: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; counter decrements; → DONE when it reaches 0.
  - DONE → IDLE unconditionally after one cycle.
- Illegal opcode: `result_lo = result_hi = 0`, `illegal = 1`, other flags 0.
- Divide by zero: `result_lo` = all ones, `result_hi = rega`, `div0 = 1`.
- Results and flags are registered; they update only on the DONE-entry edge and hold through IDLE.
- `in_valid` outside IDLE is ignored; no queueing.
- Reset asserted mid-operation aborts it: state IDLE, counter 0, no `done`.

## Timing
- Reset values: `in_ready = 1` after release (0 during reset), `done = 0`, all results and flags 0.
- Single-cycle, illegal and div-by-zero ops: accept at edge N, `done` high in cycle N+1.
- MULTU / DIVU (nonzero divisor): `done` in cycle N+WIDTH+1.
- `in_ready` low from cycle N+1 through the `done` cycle; next accept no earlier than cycle after `done` (back-to-back throughput: one single-cycle op per 2 cycles).
- Counter width `$clog2(WIDTH)+1`; no counter wrap possible.

## Configuration
- `ALU_MC_DIV_EN` defined: DIVU implemented as above.
- Not defined: divider datapath omitted; opcode 13 treated as illegal (`illegal = 1`, results 0, 1-cycle latency); MULTU unaffected.

## Structure
- Package `alu_mc_pkg`: opcode localparams, FSM state enum, `WIDTH`-independent constants.
- One sub-module `alu_mc_muldiv`: the iterative engine (partial-product/remainder register, operand shift register, counter), start/done interface to the top FSM; divider logic inside it guarded by `ALU_MC_DIV_EN`.
- Single-cycle ops remain combinational in the top, registered at DONE entry.

## Test plan
- Reset during ITER of MULTU: release → `in_ready = 1`, `done` never pulses, all outputs 0.
- ADD `rega = 32'h7FFF_FFFF`, `regb = 1` → `result_lo = 32'h8000_0000`, `ovf = 1`, `zero = 0`, `done` at N+1; SUB 5−5 → `zero = 1`, `ovf = 0`.
- SLT `rega = 32'hFFFF_FFFF`, `regb = 1` → 1; SLTU same operands → 0; SRA `regb = 32'h8000_0000`, `rega = 36` → shift 4 → `32'hF800_0000`.
- MULTU `32'hFFFF_FFFF × 32'hFFFF_FFFF` → `result_hi = 32'hFFFF_FFFE`, `result_lo = 32'h0000_0001`, `done` exactly at N+33, `in_valid` during ITER ignored.
- DIVU 100 ÷ 7 → `result_lo = 14`, `result_hi = 2` at N+33; DIVU 9 ÷ 0 → all-ones, `result_hi = 9`, `div0 = 1` at N+1; without `ALU_MC_DIV_EN` → `illegal = 1`, results 0.
- Opcode 15 → `illegal = 1`, results 0, `done` at N+1; repeat with WIDTH = 16 for MULTU `16'hFFFF × 2` → `hi = 1`, `lo = 16'hFFFE` at N+17.
